// File: rtl/ofdm_dac_stream_ctrl.sv
// Buffered OFDM DAC streamer: IFFT words in, BFP-denormalised saturated samples out on two DAC channels.
// Optional OFDM_DAC_OFFSET_BINARY_EN converts both channel outputs (idle codes included) to offset binary.
module ofdm_dac_stream_ctrl #(
    parameter int DAC_W       = 14,
    parameter int EXP_W       = 6,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 8,
    parameter int IDLE_A      = 8191,
    parameter int IDLE_B      = -8191
) (
    input  logic                     sample_clock_dac,
    input  logic                     reset_reset,
    input  logic [2*DAC_W+EXP_W-1:0] asi_in0_data,
    input  logic                     asi_in0_valid,
    output logic                     asi_in0_ready,
    input  logic                     asi_in0_startofpacket,
    input  logic                     asi_in0_endofpacket,
    output logic [DAC_W-1:0]         DAC_Control_ChA_Data,
    output logic [DAC_W-1:0]         DAC_Control_ChB_Data,
    output logic                     dac_active,
    output logic                     underrun_pulse,
    output logic [15:0]              underrun_count
);
    localparam int IN_W = 2*DAC_W + EXP_W;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WW   = 2*DAC_W + 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] PRIME_C = PRIME_LEVEL[AW:0];
    localparam logic signed [WW-1:0] SAT_HI = WW'((1 << (DAC_W-1)) - 1);
    localparam logic signed [WW-1:0] SAT_LO = -SAT_HI;
    localparam logic [DAC_W-1:0] IDLE_A_C = IDLE_A[DAC_W-1:0];
    localparam logic [DAC_W-1:0] IDLE_B_C = IDLE_B[DAC_W-1:0];
`ifdef OFDM_DAC_OFFSET_BINARY_EN
    localparam logic [DAC_W-1:0] OB_MASK = {1'b1, {(DAC_W-1){1'b0}}};
`else
    localparam logic [DAC_W-1:0] OB_MASK = '0;
`endif

    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d, eop_cnt_q, eop_cnt_d;
    logic [IN_W:0]     mem_q [FIFO_DEPTH];
    logic              last_eop_q, last_eop_d;
    logic              pipe_vld_q, pipe_vld_d;
    logic [IN_W-1:0]   pipe_word_q, pipe_word_d;
    logic [DAC_W-1:0]  cha_q, cha_d, chb_q, chb_d;
    logic              active_q, active_d, upulse_q, upulse_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic              push, pop;
    logic [IN_W:0]     head;
    logic              unused_sop;

    logic signed [DAC_W-1:0] p_re, p_im;
    logic signed [EXP_W-1:0] p_exp;

    assign unused_sop = asi_in0_startofpacket;
    assign head       = mem_q[rd_ptr_q];
    assign p_re       = pipe_word_q[IN_W-1 -: DAC_W];
    assign p_im       = pipe_word_q[DAC_W+EXP_W-1 -: DAC_W];
    assign p_exp      = pipe_word_q[EXP_W-1:0];

    assign asi_in0_ready        = (count_q < DEPTH_C);
    assign DAC_Control_ChA_Data = cha_q;
    assign DAC_Control_ChB_Data = chb_q;
    assign dac_active           = active_q;
    assign underrun_pulse       = upulse_q;
    assign underrun_count       = ucnt_q;

    // Shifts are clamped to DAC_W: anything larger already saturates (left) or collapses to 0/-1 (right).
    function automatic logic [DAC_W-1:0] scale(input logic signed [DAC_W-1:0] x,
                                                input logic signed [EXP_W-1:0] e);
        logic signed [WW-1:0] w;
        int sh;
        w  = {{(WW-DAC_W){x[DAC_W-1]}}, x};
        sh = int'(e);
        if (sh > 0) begin
            if (sh > DAC_W) sh = DAC_W;
            w = w <<< sh;
        end else if (sh < 0) begin
            sh = -sh;
            if (sh > DAC_W) sh = DAC_W;
            w = w >>> sh;
        end
        if (w > SAT_HI)      scale = SAT_HI[DAC_W-1:0];
        else if (w < SAT_LO) scale = SAT_LO[DAC_W-1:0];
        else                 scale = w[DAC_W-1:0];
    endfunction

    always_comb begin
        push        = asi_in0_valid && asi_in0_ready;
        pop         = (state_q == S_STREAM) && (count_q != '0);
        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_eop_d  = pop  ? head[0] : last_eop_q;
        pipe_vld_d  = pop;
        pipe_word_d = pop  ? head[IN_W:1] : pipe_word_q;
        upulse_d    = 1'b0;
        ucnt_d      = ucnt_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        eop_cnt_d = eop_cnt_q;
        if ((push && asi_in0_endofpacket) && !(pop && head[0]))      eop_cnt_d = eop_cnt_q + 1'b1;
        else if (!(push && asi_in0_endofpacket) && (pop && head[0])) eop_cnt_d = eop_cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                // A buffered end-of-packet flushes a short packet without waiting for priming.
                if (count_q >= PRIME_C || eop_cnt_q != '0) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                    if (!last_eop_q) begin
                        upulse_d = 1'b1;
                        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        active_d = (state_d == S_STREAM);
        cha_d    = (pipe_vld_q ? scale(p_re, p_exp) : IDLE_A_C) ^ OB_MASK;
        chb_d    = (pipe_vld_q ? scale(p_im, p_exp) : IDLE_B_C) ^ OB_MASK;
    end

    always_ff @(posedge sample_clock_dac) begin
        if (push) mem_q[wr_ptr_q] <= {asi_in0_data, asi_in0_endofpacket};
    end

    always_ff @(posedge sample_clock_dac) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            eop_cnt_q   <= '0;
            last_eop_q  <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_word_q <= '0;
            cha_q       <= IDLE_A_C ^ OB_MASK;
            chb_q       <= IDLE_B_C ^ OB_MASK;
            active_q    <= 1'b0;
            upulse_q    <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            eop_cnt_q   <= eop_cnt_d;
            last_eop_q  <= last_eop_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_word_q <= pipe_word_d;
            cha_q       <= cha_d;
            chb_q       <= chb_d;
            active_q    <= active_d;
            upulse_q    <= upulse_d;
            ucnt_q      <= ucnt_d;
        end
    end
endmodule
